// File: rtl/mmio_console_pkg.sv
// ============================================================================
// Module : mmio_console_pkg
// Brief  : Shared constants and types for the MMIO console: register offsets,
//          control FSM encodings, and the STATUS word layout.
//          The CPU5_* macros mirror the shared defines.v. They are guarded so
//          that an earlier include of defines.v takes precedence.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif
`ifndef CPU5_CON_OFF_TXDATA
`define CPU5_CON_OFF_TXDATA 2'd0
`define CPU5_CON_OFF_STATUS 2'd1
`define CPU5_CON_OFF_TOHOST 2'd2
`define CPU5_CON_OFF_RSVD   2'd3
`endif
`ifndef CPU5_CON_ST_RUN
`define CPU5_CON_ST_RUN   2'd0
`define CPU5_CON_ST_FLUSH 2'd1
`define CPU5_CON_ST_HALT  2'd2
`endif

package mmio_console_pkg;

  localparam int XLEN = `CPU5_XLEN;

  // Word offsets within the 16-byte register window (dataadr[3:2])
  localparam logic [1:0] c_off_txdata = `CPU5_CON_OFF_TXDATA;
  localparam logic [1:0] c_off_status = `CPU5_CON_OFF_STATUS;
  localparam logic [1:0] c_off_tohost = `CPU5_CON_OFF_TOHOST;
  localparam logic [1:0] c_off_rsvd   = `CPU5_CON_OFF_RSVD;

  typedef enum logic [1:0] {
    ST_RUN   = `CPU5_CON_ST_RUN,
    ST_FLUSH = `CPU5_CON_ST_FLUSH,
    ST_HALT  = `CPU5_CON_ST_HALT
  } con_state_t;

  typedef struct packed {
    logic [7:0] count;
    logic [1:0] state;
    logic       ovf;
    logic       full;
    logic       empty;
  } con_status_t;

  // Place the status fields at their architectural bit positions.
  function automatic logic [XLEN-1:0] status_word(input con_status_t s);
    logic [XLEN-1:0] w;
    w        = '0;
    w[15:8]  = s.count;
    w[4:3]   = s.state;
    w[2]     = s.ovf;
    w[1]     = s.full;
    w[0]     = s.empty;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_console_sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with first-word-fall-through output.
//          A push is accepted when not full, or when full and a pop happens
//          in the same cycle (the freed slot is reused immediately).
// Ports  : clk, reset     - clock, synchronous active-high reset
//          push, din      - write request and data
//          push_ok        - the push request this cycle is accepted
//          pop            - read request (ignored when empty)
//          dout           - head entry (valid while !empty)
//          full, empty    - occupancy flags
//          count          - occupancy, $clog2(DEPTH)+1 bits
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     push_ok,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full_count = (c_aw+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign empty   = (r_count == '0);
  assign full    = (r_count == c_full_count);
  assign count   = r_count;
  assign dout    = r_mem[r_rptr];

  assign w_pop   = pop && !empty;
  assign w_push  = push && (!full || w_pop);
  assign push_ok = w_push;

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_console.sv
// ============================================================================
// Module : mmio_console
// Brief  : Memory-mapped character console with a test-exit register.
//          Registers (word offsets from BASE):
//            0 TXDATA  W: queue writedata[7:0]          R: 0
//            1 STATUS  W: bit2=1 clears ovf             R: count/state/ovf/full/empty
//            2 TOHOST  W: nonzero ends the program      R: 0
//            3 reserved (reads 0, writes ignored)
//          After a nonzero TOHOST write the console drains its FIFO, then
//          halts with done=1; pass reports whether the exit code was 1.
// Ports  : clk, reset                   - clock, synchronous active-high reset
//          memwrite, dataadr, writedata - CPU store port
//          readdata                     - combinational register read data
//          char_valid/char_data/char_ready - character stream to the sink
//          done, pass                   - program completion and result
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif

module mmio_console
  import mmio_console_pkg::*;
#(
  parameter logic [`CPU5_XLEN-1:0] BASE  = 'h1000,
  parameter int                    DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memwrite,
  input  logic [XLEN-1:0]       dataadr,
  input  logic [XLEN-1:0]       writedata,
  output logic [XLEN-1:0]       readdata,
  output logic                  char_valid,
  output logic [7:0]            char_data,
  input  logic                  char_ready,
  output logic                  done,
  output logic                  pass
);

  con_state_t            r_state;
  logic [XLEN-1:0]       r_code;
  logic                  r_ovf;
  logic                  r_done;
  logic                  r_pass;

  logic                  w_hit;
  logic [1:0]            w_off;
  logic                  w_wr;
  logic                  w_push_req;
  logic                  w_push_ok;
  logic                  w_pop;
  logic                  w_ovf_clr;
  logic                  w_tohost;
  logic                  w_full;
  logic                  w_empty;
  logic [7:0]            w_head;
  logic [$clog2(DEPTH):0] w_count;
  con_status_t           w_status;
  logic                  w_unused;

  // Word-aligned accesses only; the byte-lane bits carry no meaning here.
  assign w_unused   = &{1'b0, dataadr[1:0]};

  assign w_hit      = (dataadr[XLEN-1:4] == BASE[XLEN-1:4]);
  assign w_off      = dataadr[3:2];
  assign w_wr       = memwrite && w_hit;

  assign w_push_req = w_wr && (w_off == c_off_txdata) && (r_state == ST_RUN);
  assign w_ovf_clr  = w_wr && (w_off == c_off_status) && writedata[2];
  assign w_tohost   = w_wr && (w_off == c_off_tohost) && (r_state == ST_RUN) &&
                      (writedata != '0);

  // Outputs are forced low while reset is held, before the first reset edge
  // has had a chance to clear the registers.
  assign char_valid = !w_empty && !reset;
  assign char_data  = w_head;
  assign w_pop      = char_valid && char_ready;
  assign done       = r_done && !reset;
  assign pass       = r_pass && !reset;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push_req),
    .din     (writedata[7:0]),
    .push_ok (w_push_ok),
    .pop     (w_pop),
    .dout    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  // Control FSM with its registered outputs (done/pass) and the ovf flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_code  <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      // A TXDATA store and a STATUS store cannot share a cycle, so the
      // set and clear of ovf never collide.
      if (w_push_req && !w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end

      case (r_state)
        ST_RUN: begin
          if (w_tohost) begin
            r_code  <= writedata;
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_empty) begin
            r_state <= ST_HALT;
            r_done  <= 1'b1;
            r_pass  <= (r_code == XLEN'(1));
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    w_status       = '0;
    w_status.count = 8'(w_count);
    w_status.state = r_state;
    w_status.ovf   = r_ovf;
    w_status.full  = w_full;
    w_status.empty = w_empty;
  end

  always_comb begin
    readdata = '0;
    if (w_hit && (w_off == c_off_status)) begin
      readdata = status_word(w_status);
    end
  end

endmodule

`default_nettype wire

// File: doc/mmio_console.md
MMIO_CONSOLE -- requirements
Module: mmio_console

Interface
REQ-001 SHALL have parameter BASE, default 'h1000: byte address of the register window; low 4 bits are zero.
REQ-002 SHALL have parameter DEPTH, default 8: character FIFO entries; a power of 2, at least 2.
REQ-003 SHALL have port clk  in  1: the single clock; every flop updates on its rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port memwrite  in  1: CPU store strobe, valid for one cycle.
REQ-006 SHALL have port dataadr  in  `CPU5_XLEN: CPU byte address.
REQ-007 SHALL have port writedata  in  `CPU5_XLEN: CPU store data.
REQ-008 SHALL have port readdata  out  `CPU5_XLEN: combinational register read data.
REQ-009 SHALL have port char_valid  out  1: a character is offered to the sink.
REQ-010 SHALL have port char_data  out  8: the character offered to the sink.
REQ-011 SHALL have port char_ready  in  1: the sink accepts the character.
REQ-012 SHALL have port done  out  1: the program has finished and all output has drained.
REQ-013 SHALL have port pass  out  1: result code; meaningful only while done=1.

Function
REQ-014 Register decode SHALL be a hit when dataadr[XLEN-1:4]==BASE[XLEN-1:4]; offset = dataadr[3:2]; 0=TXDATA, 1=STATUS, 2=TOHOST, 3=reserved (reads 0, writes ignored).
REQ-015 A TXDATA write SHALL, in state RUN, push writedata[7:0] into the FIFO; the push is accepted if count<DEPTH or a pop occurs in the same cycle.
REQ-016 A rejected TXDATA push SHALL set the sticky ovf flag; the FIFO contents SHALL be unchanged.
REQ-017 A TXDATA write outside state RUN SHALL be ignored; ovf SHALL be unchanged.
REQ-018 A STATUS read SHALL return {0, count[7:0] in bits 15:8, state[1:0] in bits 4:3, ovf in bit 2, full in bit 1, empty in bit 0}.
REQ-019 A STATUS write with writedata[2]=1 SHALL clear ovf; other bits of the write SHALL be ignored.
REQ-020 TXDATA and TOHOST reads SHALL return 0; readdata SHALL be 0 on a decode miss.
REQ-021 Drain side: char_valid SHALL equal !empty; char_data SHALL equal the FIFO head.
REQ-022 A pop SHALL occur on char_valid&&char_ready; char_data SHALL be held stable while char_valid&&!char_ready.
REQ-023 FIFO order SHALL be first-in first-out; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 count SHALL be log2(DEPTH)+1 bits wide, so that full is count==DEPTH.
REQ-025 Latency: a char pushed into an empty FIFO at edge N SHALL present char_valid=1 after edge N.
REQ-026 Control FSM states SHALL be RUN=0, FLUSH=1, HALT=2.
REQ-027 In RUN, a TOHOST write with writedata!=0 SHALL latch code=writedata and move the FSM to FLUSH.
REQ-028 In RUN, a TOHOST write with writedata==0 SHALL be ignored.
REQ-029 In FLUSH, when empty, the FSM SHALL move to HALT on the next edge.
REQ-030 In HALT the FSM SHALL stay in HALT until reset; TOHOST writes in FLUSH or HALT SHALL be ignored.
REQ-031 done SHALL equal (state==HALT); pass SHALL equal done&&(code==1).
REQ-032 A same-cycle TXDATA push and TOHOST write SHALL be impossible (single store port); a TOHOST write and a pop in the same cycle SHALL both take effect.

Reset
REQ-033 On reset=1 at a clock edge the block SHALL set: pointers=0, count=0, ovf=0, code=0, state=RUN.
REQ-034 While reset is asserted the outputs SHALL be char_valid=0, done=0, pass=0; FIFO data storage SHALL not be reset.
REQ-035 Reset mid-drain SHALL discard all queued characters, with char_valid=0 on the first cycle after the reset edge.

Structure
REQ-036 `CPU5_XLEN SHALL come from the shared defines.v.
REQ-037 Register offsets and FSM state encodings SHALL be added to defines.v as `CPU5_CON_*` constants.
REQ-038 The FIFO SHALL be a sub-module named sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count); the FSM and decode SHALL live in mmio_console.

Verification
REQ-039 Push 'H','i' with char_ready=1 -> char_data 'H' then 'i' on consecutive cycles; then empty=1.
REQ-040 char_ready=0; push 9 chars with DEPTH=8 -> full=1, ovf=1, char 9 dropped; STATUS write 4 -> ovf=0.
REQ-041 FIFO full and char_ready=1; push in the same cycle -> push accepted, count stays 8.
REQ-042 3 chars queued, char_ready=0, TOHOST=1 -> state FLUSH, done=0; release char_ready -> 3 pops, then done=1, pass=1.
REQ-043 TOHOST=3 in RUN -> done=1, pass=0; later TOHOST=1 and TXDATA writes -> no change.
REQ-044 Reset asserted with 5 chars queued and state FLUSH -> char_valid=0, state RUN, count=0 next cycle.
